// File: rtl/axil_master_cmd_adaptor.sv
// AXI4-Lite initiator: turns a single-beat valid/ready command into one AXI-Lite transaction and one response.
// Optional watchdog enabled by defining AXIL_MASTER_CMD_TIMEOUT_EN.
module axil_master_cmd_adaptor #(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    localparam int size_width_lp = $clog2($clog2(axil_data_width_p/8) + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           cmd_v_i,
    output logic                           cmd_ready_and_o,
    input  logic [axil_addr_width_p-1:0]   cmd_addr_i,
    input  logic                           cmd_wr_en_i,
    input  logic [size_width_lp-1:0]       cmd_data_size_i,
    input  logic [axil_data_width_p-1:0]   cmd_wdata_i,
    output logic                           resp_v_o,
    input  logic                           resp_ready_and_i,
    output logic [axil_data_width_p-1:0]   resp_rdata_o,
    output logic                           resp_err_o,
    output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
    output logic [2:0]                     m_axil_awprot_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,
    output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
    output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,
    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o,
    output logic [axil_addr_width_p-1:0]   m_axil_araddr_o,
    output logic [2:0]                     m_axil_arprot_o,
    output logic                           m_axil_arvalid_o,
    input  logic                           m_axil_arready_i,
    input  logic [axil_data_width_p-1:0]   m_axil_rdata_i,
    input  logic [1:0]                     m_axil_rresp_i,
    input  logic                           m_axil_rvalid_i,
    output logic                           m_axil_rready_o
);

    localparam int lanes_lp    = axil_data_width_p / 8;
    localparam int lg_lanes_lp = $clog2(lanes_lp);

    typedef enum logic [2:0] {e_ready, e_write, e_wait_b, e_read, e_wait_r, e_resp} state_e;

    state_e                         state_reg, state_next;
    logic [axil_addr_width_p-1:0]   addr_reg;
    logic [size_width_lp-1:0]       size_reg;
    logic [axil_data_width_p-1:0]   wdata_reg, rdata_reg;
    logic                           aw_done_reg, w_done_reg, err_reg;

    logic [lg_lanes_lp-1:0]         size_mask, offset;
    logic [axil_data_width_p-1:0]   wdata_rep, rdata_fmt;
    logic [lanes_lp-1:0]            wstrb;
    logic cmd_fire, aw_fire, w_fire, b_fire, r_fire, aw_fin, w_fin, busy, timeout_hit, to_fire;
    logic unused_bits;

    assign cmd_fire = cmd_v_i & cmd_ready_and_o;
    assign aw_fire  = m_axil_awvalid_o & m_axil_awready_i;
    assign w_fire   = m_axil_wvalid_o & m_axil_wready_i;
    // Only beats arriving while waiting count; late beats in e_ready are discarded.
    assign b_fire   = (state_reg == e_wait_b) & m_axil_bvalid_i;
    assign r_fire   = (state_reg == e_wait_r) & m_axil_rvalid_i;
    assign aw_fin   = aw_done_reg | aw_fire;
    assign w_fin    = w_done_reg | w_fire;
    assign busy     = (state_reg != e_ready) & (state_reg != e_resp);
    assign to_fire  = timeout_hit & ~b_fire & ~r_fire;
    assign unused_bits = &{1'b0, m_axil_bresp_i[0], m_axil_rresp_i[0]};

`ifdef AXIL_MASTER_CMD_TIMEOUT_EN
    logic [15:0] timer_reg;
    always_ff @(posedge clk_i) begin
        if (reset_i)       timer_reg <= '0;
        else if (cmd_fire) timer_reg <= '0;
        else if (busy)     timer_reg <= timer_reg + 16'd1;
    end
    assign timeout_hit = busy & (timer_reg == 16'hFFFF);
`else
    assign timeout_hit = 1'b0;
`endif

    // Lane offset is the address aligned down to the access size.
    for (genvar gi = 0; gi < lg_lanes_lp; gi++) begin : g_mask
        assign size_mask[gi] = (32'(size_reg) > gi);
    end
    assign offset = addr_reg[lg_lanes_lp-1:0] & ~size_mask;

    for (genvar gi = 0; gi < lanes_lp; gi++) begin : g_lane
        localparam logic [lg_lanes_lp-1:0] lane_c = lg_lanes_lp'(gi);
        assign wdata_rep[8*gi +: 8] = wdata_reg[{lane_c & size_mask, 3'b000} +: 8];
        assign wstrb[gi]            = ((lane_c & ~size_mask) == offset);
        assign rdata_fmt[8*gi +: 8] = ((lane_c & size_mask) == lane_c)
                                    ? m_axil_rdata_i[{lane_c | offset, 3'b000} +: 8] : 8'h00;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_reg <= e_ready;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            e_ready:  if (cmd_v_i) state_next = cmd_wr_en_i ? e_write : e_read;
            e_write:  if (aw_fin & w_fin) state_next = e_wait_b;
            e_wait_b: if (b_fire) state_next = e_resp;
            e_read:   if (m_axil_arready_i) state_next = e_wait_r;
            e_wait_r: if (r_fire) state_next = e_resp;
            e_resp:   if (resp_ready_and_i) state_next = e_ready;
            default:  state_next = e_ready;
        endcase
        if (to_fire) state_next = e_resp;
    end

    always_comb begin
        cmd_ready_and_o  = 1'b0;
        resp_v_o         = 1'b0;
        m_axil_awvalid_o = 1'b0;
        m_axil_wvalid_o  = 1'b0;
        m_axil_bready_o  = 1'b0;
        m_axil_arvalid_o = 1'b0;
        m_axil_rready_o  = 1'b0;
        unique case (state_reg)
            e_ready: begin
                cmd_ready_and_o = 1'b1;
`ifdef AXIL_MASTER_CMD_TIMEOUT_EN
                m_axil_bready_o = 1'b1;
                m_axil_rready_o = 1'b1;
`endif
            end
            e_write: begin
                m_axil_awvalid_o = ~aw_done_reg;
                m_axil_wvalid_o  = ~w_done_reg;
            end
            e_wait_b: m_axil_bready_o  = 1'b1;
            e_read:   m_axil_arvalid_o = 1'b1;
            e_wait_r: m_axil_rready_o  = 1'b1;
            e_resp:   resp_v_o         = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_reg    <= '0;
            size_reg    <= '0;
            wdata_reg   <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            err_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            if (cmd_fire) begin
                addr_reg    <= cmd_addr_i;
                size_reg    <= cmd_data_size_i;
                wdata_reg   <= cmd_wdata_i;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end
            if (aw_fire) aw_done_reg <= 1'b1;
            if (w_fire)  w_done_reg  <= 1'b1;
            if (b_fire) begin
                err_reg   <= m_axil_bresp_i[1];
                rdata_reg <= '0;
            end else if (r_fire) begin
                err_reg   <= m_axil_rresp_i[1];
                rdata_reg <= rdata_fmt;
            end else if (to_fire) begin
                err_reg   <= 1'b1;
                rdata_reg <= '0;
            end
        end
    end

    assign m_axil_awaddr_o = addr_reg;
    assign m_axil_araddr_o = addr_reg;
    assign m_axil_awprot_o = 3'b000;
    assign m_axil_arprot_o = 3'b000;
    assign m_axil_wdata_o  = wdata_rep;
    assign m_axil_wstrb_o  = wstrb;
    assign resp_rdata_o    = rdata_reg;
    assign resp_err_o      = err_reg;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i && cmd_fire && (32'(cmd_data_size_i) > lg_lanes_lp))
            $error("axil_master_cmd_adaptor: size %0d exceeds data width", cmd_data_size_i);
    end
`endif

endmodule

// File: doc/axil_master_cmd_adaptor.md
Name: axil_master_cmd_adaptor

Overview:
- AXI4-Lite initiator. Converts a single-beat valid/ready command stream (addr, wr_en, size, wdata) into AXI-Lite master transactions and returns one response per command.
- It is the host-side counterpart of the PL client adaptor. Lets PL logic (e.g. a BlackParrot I/O bridge or a DMA sequencer) issue MMIO accesses to AXI-Lite peripherals such as the ethernet controller.
- Exactly one outstanding transaction.

Parameters:
- axil_data_width_p, 32, AXI-Lite data width; must be 32 or 64.
- axil_addr_width_p, 32, AXI-Lite address width.
- size_width_lp (localparam), `BSG_WIDTH(`BSG_SAFE_CLOG2(axil_data_width_p/8)), width of the log2-bytes size field.

Ports:
- clk_i  in  1  clock; all logic is in this single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- cmd_v_i  in  1  command valid.
- cmd_ready_and_o  out  1  command ready (ready-and handshake).
- cmd_addr_i  in  axil_addr_width_p  byte address.
- cmd_wr_en_i  in  1  1 = write, 0 = read.
- cmd_data_size_i  in  size_width_lp  log2 bytes (0 = B, 1 = H, 2 = W, 3 = D when width is 64).
- cmd_wdata_i  in  axil_data_width_p  write data, LSB-aligned.
- resp_v_o  out  1  response valid.
- resp_ready_and_i  in  1  response ready.
- resp_rdata_o  out  axil_data_width_p  read data, LSB-aligned, zero-extended; 0 for writes.
- resp_err_o  out  1  1 when the AXI response was SLVERR/DECERR (or timeout).
- m_axil_awaddr_o  out  addr_width  write address.
- m_axil_awprot_o  out  3  write protection.
- m_axil_awvalid_o  out  1  write address valid.
- m_axil_awready_i  in  1  write address ready.
- m_axil_wdata_o  out  data_width  write data.
- m_axil_wstrb_o  out  data_width/8  write strobes.
- m_axil_wvalid_o  out  1  write data valid.
- m_axil_wready_i  in  1  write data ready.
- m_axil_bresp_i  in  2  write response.
- m_axil_bvalid_i  in  1  write response valid.
- m_axil_bready_o  out  1  write response ready.
- m_axil_araddr_o  out  addr_width  read address.
- m_axil_arprot_o  out  3  read protection.
- m_axil_arvalid_o  out  1  read address valid.
- m_axil_arready_i  in  1  read address ready.
- m_axil_rdata_i  in  data_width  read data.
- m_axil_rresp_i  in  2  read response.
- m_axil_rvalid_i  in  1  read data valid.
- m_axil_rready_o  out  1  read data ready.

Behaviour:
- Reset values: every valid/ready output is 0, except cmd_ready_and_o = 1 after reset; resp_err_o = 0; state = e_ready.
- Protection: awprot/arprot are tied to 3'b000.
- Command capture:
  - In e_ready, cmd_ready_and_o = 1.
  - On cmd_v_i & cmd_ready_and_o, register addr, wr_en, size and wdata.
  - Go to e_write if wr_en, else e_read.
  - cmd_ready_and_o = 0 in every other state.
- Address: awaddr/araddr drive the registered addr unmodified. Lane offset is addr[clog2(data_width/8)-1:0], masked down to size alignment.
- Write data path:
  - wdata is the LSB-aligned data replicated across all lanes.
  - wstrb = ((1 << (1 << size)) - 1) << offset.
- e_write:
  - awvalid and wvalid assert on the first cycle after capture and deassert independently as each handshake completes; flags aw_done_r and w_done_r track completion.
  - Handshakes in the same cycle or in either order are legal.
  - When both are done, go to e_wait_b.
  - Valids never drop before their ready.
- e_wait_b: bready = 1. On bvalid, latch err = bresp[1], rdata = 0, and go to e_resp.
- e_read: arvalid = 1. On arready, go to e_wait_r.
- e_wait_r: rready = 1. On rvalid, latch err = rresp[1] and rdata = (rdata_i >> 8*offset), masked to 8<<size bits. Go to e_resp.
- e_resp: resp_v_o = 1 with the outputs held stable. On resp_ready_and_i, go to e_ready.
- Latency (zero-wait slave):
  - Read: command accept → arvalid at +1, resp_v_o at +3.
  - Write: resp_v_o at +3.
- No back-to-back acceptance: the next command is accepted no earlier than the cycle after the response handshake.
- Reset mid-transaction: all state returns to reset values immediately and the in-flight transaction is abandoned. The system must also reset the slave.
- Data widths and size: size > log2(data_width/8) is illegal. A simulation-only $error fires on it.

Optional Feature:
- Macro: AXIL_MASTER_CMD_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on command accept and increments in every non-ready, non-resp state.
  - When it reaches 16'hFFFF, go to e_resp with resp_err_o = 1 and rdata = 0.
  - All AXI valids/readies deassert.
  - A late B/R beat arriving afterwards is accepted and dropped only while in e_ready; bready/rready stay 1 in e_ready for that purpose.
- Without the macro: no counter; the FSM waits indefinitely, and bready/rready are 0 in e_ready.

Test Plan:
- Word write addr 0x1000, data 0xDEADBEEF, size 2, zero-wait slave, bresp OKAY → awaddr 0x1000, wstrb 4'b1111, resp_v_o at cycle +3, resp_err_o 0.
- Byte write addr 0x1003, data 0xA5, size 0 → wdata 0xA5A5A5A5, wstrb 4'b1000.
- Half read addr 0x2002, slave rdata 0x12345678 → resp_rdata_o 0x00001234.
- Write where wready arrives 3 cycles before awready, and a second case with them reversed → exactly one AW and one W handshake each, one response; bresp 2'b10 → resp_err_o 1.
- resp_ready_and_i held low 5 cycles with cmd_v_i high → cmd_ready_and_o 0 throughout, response held stable, next command accepted the cycle after the response handshake.
- (TIMEOUT_EN) Slave never asserts arready → resp_v_o with err 1 and rdata 0 after 65535 cycles; reset asserted mid-read → all valids 0 the next cycle and cmd_ready_and_o 1 after reset deasserts.
